// File: rtl/rgb_pkg.sv
// Shared constants for the RGB-to-grayscale datapath: BT.601 weights,
// coefficient select encodings and the float zero literal.
package rgb_pkg;

    localparam logic [31:0] BT601_R  = 32'h3E991687;  // 0.299
    localparam logic [31:0] BT601_G  = 32'h3F1645A2;  // 0.587
    localparam logic [31:0] BT601_B  = 32'h3DE978D5;  // 0.114
    localparam logic [31:0] FLT_ZERO = 32'h00000000;

    typedef enum logic [1:0] {
        SEL_R    = 2'd0,
        SEL_G    = 2'd1,
        SEL_B    = 2'd2,
        SEL_RSVD = 2'd3
    } cfg_sel_e;

endpackage

// File: rtl/cong_32bit.sv
// IEEE-754 single adder, round to nearest even; zero/denormal operands pass the other through.
module cong_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic [31:0]       big, sml;
    logic [7:0]        d;
    logic [26:0]       bm, sm_ext, sm_sh;
    logic              sticky;
    logic [27:0]       sum;
    logic [25:0]       n;
    logic [4:0]        lz;
    logic              found;
    logic signed [9:0] e;
    logic [23:0]       mr;

    always_comb begin
        big    = a;
        sml    = b;
        d      = '0;
        bm     = '0;
        sm_ext = '0;
        sm_sh  = '0;
        sticky = 1'b0;
        sum    = '0;
        n      = '0;
        lz     = '0;
        found  = 1'b0;
        e      = '0;
        mr     = '0;
        y      = a;
        if (a[30:23] == 8'd0) begin
            y = b;
        end else if (b[30:23] != 8'd0) begin
            if (a[30:0] < b[30:0]) begin
                big = b;
                sml = a;
            end
            d      = big[30:23] - sml[30:23];
            bm     = {1'b1, big[22:0], 3'b000};
            sm_ext = {1'b1, sml[22:0], 3'b000};
            // Three guard bits plus a sticky LSB keep rounding exact.
            if (d >= 8'd27) begin
                sm_sh  = '0;
                sticky = 1'b1;
            end else begin
                sm_sh  = sm_ext >> d;
                sticky = |(sm_ext & ~(27'h7FFFFFF << d));
            end
            sm_sh[0] = sm_sh[0] | sticky;
            if (big[31] == sml[31])
                sum = {1'b0, bm} + {1'b0, sm_sh};
            else
                sum = {1'b0, bm} - {1'b0, sm_sh};
            e = $signed({2'b0, big[30:23]});
            if (sum == 28'd0) begin
                y = 32'h0;
            end else begin
                if (sum[27]) begin
                    n = {sum[26:2], sum[1] | sum[0]};
                    e = e + 10'sd1;
                end else begin
                    for (int i = 26; i >= 0; i--) begin
                        if (!found && sum[i]) begin
                            lz    = 5'(26 - i);
                            found = 1'b1;
                        end
                    end
                    n = 26'(sum[26:0] << lz);
                    e = e - $signed({5'b0, lz});
                end
                mr = {1'b0, n[25:3]} + 24'(n[2] & (n[1] | n[0] | n[3]));
                if (mr[23])
                    e = e + 10'sd1;
                if (e <= 10'sd0)
                    y = {big[31], 31'b0};
                else if (e >= 10'sd255)
                    y = {big[31], 8'hFF, 23'b0};
                else
                    y = {big[31], e[7:0], mr[22:0]};
            end
        end
    end

endmodule

// File: rtl/int_to_float.sv
// Unsigned 32-bit integer to IEEE-754 single, round to nearest even.
module int_to_float (
    input  logic [31:0] a,
    output logic [31:0] y
);

    logic [4:0]  lz;
    logic        found;
    logic [30:0] norm;
    logic        rnd;
    logic [23:0] mr;

    always_comb begin
        y     = '0;
        lz    = '0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && a[i]) begin
                lz    = 5'(31 - i);
                found = 1'b1;
            end
        end
        // Hidden bit is shifted out; bits [30:8] are the mantissa.
        norm = 31'(a << lz);
        rnd  = norm[7] & ((|norm[6:0]) | norm[8]);
        mr   = {1'b0, norm[30:8]} + 24'(rnd);
        if (a != 32'd0)
            y = {1'b0, 8'(8'd158 - {3'b0, lz} + {7'b0, mr[23]}), mr[22:0]};
    end

endmodule

// File: rtl/mul_float.sv
// IEEE-754 single multiply, round to nearest even; zero/denormal inputs flush to zero.
module mul_float (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic               sign;
    logic [47:0]        prod;
    logic signed [9:0]  e;
    logic [22:0]        m;
    logic               g;
    logic               st;
    logic [23:0]        mr;

    always_comb begin
        sign = a[31] ^ b[31];
        prod = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e    = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127;
        m    = '0;
        g    = 1'b0;
        st   = 1'b0;
        mr   = '0;
        y    = {sign, 31'b0};
        if (a[30:23] != 8'd0 && b[30:23] != 8'd0) begin
            if (prod[47]) begin
                m  = prod[46:24];
                g  = prod[23];
                st = |prod[22:0];
                e  = e + 10'sd1;
            end else begin
                m  = prod[45:23];
                g  = prod[22];
                st = |prod[21:0];
            end
            mr = {1'b0, m} + 24'(g & (st | m[0]));
            if (mr[23])
                e = e + 10'sd1;
            if (e <= 10'sd0)
                y = {sign, 31'b0};
            else if (e >= 10'sd255)
                y = {sign, 8'hFF, 23'b0};
            else
                y = {sign, e[7:0], mr[22:0]};
        end
    end

endmodule

// File: rtl/rgb_coef_regs.sv
// Bank of three float coefficients; the caller gates the write strobe.
module rgb_coef_regs
    import rgb_pkg::*;
#(
    parameter logic [31:0] RST_R = BT601_R,
    parameter logic [31:0] RST_G = BT601_G,
    parameter logic [31:0] RST_B = BT601_B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [1:0]  sel,
    input  logic [31:0] data,
    output logic [31:0] coef_r,
    output logic [31:0] coef_g,
    output logic [31:0] coef_b
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_r <= RST_R;
            coef_g <= RST_G;
            coef_b <= RST_B;
        end else if (we) begin
            case (cfg_sel_e'(sel))
                SEL_R:   coef_r <= data;
                SEL_G:   coef_g <= data;
                SEL_B:   coef_b <= data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rgb2gray_pipe.sv
// Four-stage float grayscale pipeline, Y = Cr*R + Cg*G + Cb*B, with a global stall.
// Handshake: a beat transfers on a rising edge where valid & ready are both 1; ready never depends on valid.
module rgb2gray_pipe
    import rgb_pkg::*;
#(
    parameter int          PIX_W  = 8,
    parameter int          CNT_W  = 24,
    parameter logic [31:0] COEF_R = BT601_R,
    parameter logic [31:0] COEF_G = BT601_G,
    parameter logic [31:0] COEF_B = BT601_B
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_r,
    input  logic [PIX_W-1:0] in_g,
    input  logic [PIX_W-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [31:0]      cfg_data,
    output logic             cfg_ready,
    output logic [CNT_W-1:0] pix_cnt
);

    logic        en;
    logic        v1, v2, v3, v4;
    logic [31:0] r_ext, g_ext, b_ext;
    logic [31:0] i2f_r, i2f_g, i2f_b;
    logic [31:0] f_r, f_g, f_b;
    logic [31:0] mul_r, mul_g, mul_b;
    logic [31:0] p_r, p_g, p_b;
    logic [31:0] add1, s3_sum, s3_b;
    logic [31:0] add2, y4;
    logic [31:0] coef_r, coef_g, coef_b;

    // Only an output held against back-pressure freezes the whole pipe.
    assign en        = ~(v4 & ~out_ready);
    assign in_ready  = en;
    assign cfg_ready = ~(v1 | v2 | v3 | v4) & ~in_valid;
    assign out_valid = v4;
    assign out_y     = y4;

    assign r_ext = 32'(in_r);
    assign g_ext = 32'(in_g);
    assign b_ext = 32'(in_b);

    rgb_coef_regs #(.RST_R(COEF_R), .RST_G(COEF_G), .RST_B(COEF_B)) u_coef (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (cfg_we & cfg_ready),
        .sel    (cfg_sel),
        .data   (cfg_data),
        .coef_r (coef_r),
        .coef_g (coef_g),
        .coef_b (coef_b)
    );

    int_to_float u_i2f_r (.a(r_ext), .y(i2f_r));
    int_to_float u_i2f_g (.a(g_ext), .y(i2f_g));
    int_to_float u_i2f_b (.a(b_ext), .y(i2f_b));

    mul_float u_mul_r (.a(f_r), .b(coef_r), .y(mul_r));
    mul_float u_mul_g (.a(f_g), .b(coef_g), .y(mul_g));
    mul_float u_mul_b (.a(f_b), .b(coef_b), .y(mul_b));

    cong_32bit u_add1 (.a(p_r),    .b(p_g),  .y(add1));
    cong_32bit u_add2 (.a(s3_sum), .b(s3_b), .y(add2));

    // Data registers load on bubbles too; only the valid bits carry meaning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v1, v2, v3, v4} <= 4'b0;
            f_r    <= FLT_ZERO;
            f_g    <= FLT_ZERO;
            f_b    <= FLT_ZERO;
            p_r    <= FLT_ZERO;
            p_g    <= FLT_ZERO;
            p_b    <= FLT_ZERO;
            s3_sum <= FLT_ZERO;
            s3_b   <= FLT_ZERO;
            y4     <= FLT_ZERO;
        end else if (en) begin
            v1     <= in_valid;
            f_r    <= i2f_r;
            f_g    <= i2f_g;
            f_b    <= i2f_b;
            v2     <= v1;
            p_r    <= mul_r;
            p_g    <= mul_g;
            p_b    <= mul_b;
            v3     <= v2;
            s3_sum <= add1;
            s3_b   <= p_b;
            v4     <= v3;
            y4     <= add2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pix_cnt <= '0;
        else if (v4 & out_ready)
            pix_cnt <= pix_cnt + 1'b1;
    end

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// Directed bench for rgb2gray_pipe: a default-width DUT plus a CNT_W=4 twin
// sharing all inputs, an output scoreboard and hand-computed float results.
module tb_rgb2gray_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
  logic        out_ready = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [31:0] cfg_data = '0;

  logic        in_ready, out_valid, cfg_ready;
  logic [31:0] out_y;
  logic [23:0] pix_cnt;
  logic        in_ready2, out_valid2, cfg_ready2;
  logic [31:0] out_y2;
  logic [3:0]  pix_cnt2;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt = 0;

  logic [31:0] exp_q[$];
  int          tol_q[$];
  logic [31:0] mon_exp;
  int          mon_tol;

  logic [31:0] stream_exp[8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

  always #5 clk = ~clk;

  rgb2gray_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .pix_cnt(pix_cnt)
  );

  rgb2gray_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .out_valid(out_valid2), .out_ready(out_ready),
    .out_y(out_y2), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready2), .pix_cnt(pix_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol = 0);
    longint diff;
    n_checks++;
    diff = longint'(obs) - longint'(exp);
    if (diff < 0) diff = -diff;
    if ($isunknown(obs) || diff > tol) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (tol %0d ulp)", tag, obs, exp, tol);
    end
  endtask

  // scoreboard: compare every delivered pixel against the expected queue
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tol = tol_q.pop_front();
        check("out_y", out_y, mon_exp, mon_tol);
      end
    end
  end

  // called in the posedge+1 phase; returns in the same phase after acceptance
  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [31:0] exp, input int tol);
    int   guard = 0;
    logic rdy = 1'b0;
    exp_q.push_back(exp);
    tol_q.push_back(tol);
    in_valid = 1'b1;
    in_r = r;
    in_g = g;
    in_b = b;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 100);
    if (!rdy) check("send_timeout", 32'd0, 32'd1);
    else acc_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data, input logic exp_rdy);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_data = data;
    @(negedge clk);
    check("cfg_ready", 32'(cfg_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_low;
    int   held;
    saw_low = 1'b0;
    held = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_y", out_y, 32'h0);
    check("rst_pix_cnt", 32'(pix_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_cfg_ready", 32'(cfg_ready), 32'd1);

    // latency: accepted on edge 1, out_valid after edge 4
    exp_q.push_back(32'h42C80000);
    tol_q.push_back(2);
    in_valid = 1'b1;
    in_r = 8'd100; in_g = 8'd100; in_b = 8'd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("lat_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    wait_drain();
    check("pix_cnt_1", 32'(pix_cnt), 32'd1);

    // default coefficients, pure red and black
    send(8'd255, 8'd0, 8'd0, 32'h42987D70, 2);
    send(8'd0, 8'd0, 8'd0, 32'h00000000, 0);
    wait_drain();

    // coefficient reload on idle pipe: Y = R
    cfg_write(SEL_R_T(), 32'h3F800000, 1'b1);
    cfg_write(2'd1, 32'h00000000, 1'b1);
    cfg_write(2'd2, 32'h00000000, 1'b1);
    send(8'd37, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 32'h42140000, 0);
    cfg_write(2'd0, 32'h40000000, 1'b0);  // pixel in flight: dropped
    wait_drain();
    send(8'd37, 8'd200, 8'd17, 32'h42140000, 0);
    wait_drain();
    fork
      send(8'd5, 8'd99, 8'd250, 32'h40A00000, 0);
      cfg_write(2'd0, 32'h40000000, 1'b0);  // concurrent with in_valid: dropped
    join
    send(8'd50, 8'($urandom_range(0, 255)), 8'd3, 32'h42480000, 0);
    wait_drain();
    cfg_write(2'd3, 32'h40000000, 1'b1);  // reserved select: ignored
    send(8'd10, 8'd77, 8'($urandom_range(0, 255)), 32'h41200000, 0);
    wait_drain();

    // 8-pixel stream with a 6-cycle output stall
    acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(8'(i + 1), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), stream_exp[i], 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          if (!in_ready && !saw_low) begin
            saw_low = 1'b1;
            held = acc_cnt;
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_in_ready_low", 32'(saw_low), 32'd1);
    check("stall_held_pixels", 32'(held), 32'd4);
    check("pix_cnt_16", 32'(pix_cnt), 32'd16);
    check("pix_cnt4_wrap16", 32'(pix_cnt2), 32'd0);

    // reset with three pixels in flight and out_valid held high
    out_ready = 1'b0;
    send(8'd9, 8'd9, 8'd9, 32'h0, 0);
    send(8'd9, 8'd9, 8'd9, 32'h0, 0);
    send(8'd9, 8'd9, 8'd9, 32'h0, 0);
    @(posedge clk); #1;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    tol_q.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_y", out_y, 32'h0);
    check("midrst_pix_cnt", 32'(pix_cnt), 32'd0);
    check("midrst_pix_cnt4", 32'(pix_cnt2), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_cfg_ready", 32'(cfg_ready), 32'd1);
    send(8'd100, 8'd100, 8'd100, 32'h42C80000, 2);

    // 4-bit counter wrap over 17 deliveries
    for (int i = 0; i < 15; i++) begin
      if (i % 2 == 1) send(8'd100, 8'd100, 8'd100, 32'h42C80000, 2);
      else send(8'd0, 8'd0, 8'd0, 32'h00000000, 0);
    end
    wait_drain();
    check("pix_cnt_16b", 32'(pix_cnt), 32'd16);
    check("pix_cnt4_wrap", 32'(pix_cnt2), 32'd0);
    send(8'd0, 8'd0, 8'd0, 32'h00000000, 0);
    wait_drain();
    check("pix_cnt_17", 32'(pix_cnt), 32'd17);
    check("pix_cnt4_after_wrap", 32'(pix_cnt2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  function automatic logic [1:0] SEL_R_T();
    return 2'd0;
  endfunction

endmodule
